// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the VGA generator and receiver,
// plus the receiver lock-state encoding.
package vga_timing_pkg;

  localparam int H_SYNC      = 96;
  localparam int H_BACK      = 48;
  localparam int H_ACT       = 640;
  localparam int H_FRONT     = 16;
  localparam int V_SYNC      = 2;
  localparam int V_BACK      = 33;
  localparam int V_ACT       = 480;
  localparam int V_FRONT     = 10;
  localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int LOCK_FRAMES = 2;
  localparam int H_TIMEOUT   = 2048;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous active-low sync input, followed by
// a falling-edge detector that only compares samples taken on pixel enables.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic pix_ce,
  input  logic din,
  output logic fall
);

  logic [1:0] sync_ff;
  logic       prev;

  // Flops idle high so a reset never fabricates an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= 2'b11;
      prev    <= 1'b1;
    end else begin
      sync_ff <= {sync_ff[0], din};
      if (pix_ce) prev <= sync_ff[1];
    end
  end

  assign fall = pix_ce & prev & ~sync_ff[1];

endmodule

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: measures incoming HS/VS line and frame lengths, locks to
// the nominal timing and regenerates x/y/de for downstream capture logic.
//   state   | meaning
//   SEARCH  | no timing reference; waiting for a good frame
//   ACQUIRE | good_cnt consecutive good frames seen
//   LOCKED  | timing trusted; de/x/y valid
module vga_sync_rx #(
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BACK      = vga_timing_pkg::H_BACK,
  parameter int H_ACT       = vga_timing_pkg::H_ACT,
  parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BACK      = vga_timing_pkg::V_BACK,
  parameter int V_ACT       = vga_timing_pkg::V_ACT,
  parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES,
  parameter int H_TIMEOUT   = vga_timing_pkg::H_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        de,
  output logic        line_start,
  output logic        frame_start,
  output logic [10:0] meas_h,
  output logic [9:0]  meas_v,
  output logic        locked,
  output logic        err
);

  import vga_timing_pkg::*;

  localparam int          GW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [10:0] H_TOT_L = 11'(H_SYNC + H_BACK + H_ACT + H_FRONT);
  localparam logic [9:0]  V_TOT_L = 10'(V_SYNC + V_BACK + V_ACT + V_FRONT);
  localparam logic [10:0] H_TO    = 11'(H_TIMEOUT - 1);
  localparam logic [10:0] H_MAX   = 11'h7ff;
  localparam logic [9:0]  V_MAX   = 10'h3ff;
  localparam logic [10:0] X_LO    = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] X_HI    = 11'(H_SYNC + H_BACK + H_ACT - 1);
  localparam logic [9:0]  Y_LO    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  Y_HI    = 10'(V_SYNC + V_BACK + V_ACT - 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);

  rx_state_t       state, state_nxt;
  logic [GW-1:0]   good_cnt, good_nxt;
  logic            err_nxt;
  logic            hs_fall, vs_fall;
  logic [10:0]     h_cnt, h_cnt_nxt, meas_h_nxt;
  logic [9:0]      v_cnt, v_cnt_nxt, meas_v_nxt;
  logic            vs_pend, bad_line;
  logic            pend_now, frame_evt, line_bad, frame_good, timeout;
  logic            de_nxt;

  sync_edge_det u_hs_det (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (pix_ce),
    .din    (hs_in),
    .fall   (hs_fall)
  );

  sync_edge_det u_vs_det (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (pix_ce),
    .din    (vs_in),
    .fall   (vs_fall)
  );

  assign meas_h_nxt = h_cnt + 11'd1;
  assign meas_v_nxt = v_cnt + 10'd1;
  // A VS fall landing on the same sample as the HS fall commits immediately.
  assign pend_now   = vs_pend | vs_fall;
  assign frame_evt  = hs_fall & pend_now;
  assign line_bad   = hs_fall & (meas_h_nxt != H_TOT_L);
  assign frame_good = (meas_v_nxt == V_TOT_L) & ~bad_line & ~line_bad;
  assign timeout    = pix_ce & (h_cnt == H_TO);
  assign locked     = (state == LOCKED);

  always_comb begin
    h_cnt_nxt = h_cnt;
    v_cnt_nxt = v_cnt;
    if (pix_ce) begin
      if (hs_fall)             h_cnt_nxt = '0;
      else if (h_cnt != H_MAX) h_cnt_nxt = h_cnt + 11'd1;
      if (frame_evt)                     v_cnt_nxt = '0;
      else if (hs_fall && v_cnt != V_MAX) v_cnt_nxt = v_cnt + 10'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    if (timeout) begin
      state_nxt = SEARCH;
      good_nxt  = '0;
      err_nxt   = (state == LOCKED);
    end else begin
      case (state)
        SEARCH: begin
          if (frame_evt && frame_good) begin
            good_nxt  = GW'(1);
            state_nxt = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (frame_evt) begin
            if (frame_good) begin
              good_nxt = good_cnt + GW'(1);
              if (good_nxt >= LOCK_N) state_nxt = LOCKED;
            end else begin
              good_nxt  = '0;
              state_nxt = SEARCH;
            end
          end
        end
        LOCKED: begin
          // Lines are judged as they end; no waiting for the frame boundary.
          if (line_bad || (frame_evt && !frame_good)) begin
            good_nxt  = '0;
            state_nxt = SEARCH;
            err_nxt   = 1'b1;
          end
        end
        default: begin
          good_nxt  = '0;
          state_nxt = SEARCH;
        end
      endcase
    end
  end

  assign de_nxt = (state_nxt == LOCKED) &&
                  (h_cnt_nxt >= X_LO) && (h_cnt_nxt <= X_HI) &&
                  (v_cnt_nxt >= Y_LO) && (v_cnt_nxt <= Y_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEARCH;
      good_cnt    <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      vs_pend     <= 1'b0;
      bad_line    <= 1'b0;
      meas_h      <= '0;
      meas_v      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
    end else begin
      state       <= state_nxt;
      good_cnt    <= good_nxt;
      h_cnt       <= h_cnt_nxt;
      v_cnt       <= v_cnt_nxt;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      err         <= err_nxt;
      if (pix_ce) begin
        if (hs_fall) begin
          meas_h     <= meas_h_nxt;
          line_start <= 1'b1;
        end
        if (frame_evt) begin
          meas_v      <= meas_v_nxt;
          frame_start <= 1'b1;
          vs_pend     <= 1'b0;
          bad_line    <= 1'b0;
        end else begin
          vs_pend <= pend_now;
          if (line_bad) bad_line <= 1'b1;
        end
        de <= de_nxt;
        x  <= de_nxt ? 10'(h_cnt_nxt - X_LO) : 10'd0;
        y  <= de_nxt ? 9'(v_cnt_nxt - Y_LO)  : 9'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a shrunken 25x11 raster: a pixel-level reference
// model queues the expected outputs of every pixel sample.
module tb_vga_sync_rx;

  localparam int HS_W = 4, HB = 3, HA = 16, HF = 2;
  localparam int VS_W = 1, VB = 2, VA = 6, VF = 2;
  localparam int HT = HS_W + HB + HA + HF;
  localparam int VT = VS_W + VB + VA + VF;
  localparam int XL = HS_W + HB, XH = HS_W + HB + HA - 1;
  localparam int YL = VS_W + VB, YH = VS_W + VB + VA - 1;
  localparam int LOCKF = 2;
  localparam int TO = 2048;

  logic        clk, rst, pix_ce, hs_in, vs_in;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        de, line_start, frame_start, locked, err;
  logic [10:0] meas_h;
  logic [9:0]  meas_v;

  vga_sync_rx #(
    .H_SYNC(HS_W), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
    .V_SYNC(VS_W), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
    .LOCK_FRAMES(LOCKF), .H_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .hs_in(hs_in), .vs_in(vs_in),
    .x(x), .y(y), .de(de), .line_start(line_start), .frame_start(frame_start),
    .meas_h(meas_h), .meas_v(meas_v), .locked(locked), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] mh;
    logic [9:0]  mv;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        de, ls, fs, lk, er;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference model state, advanced once per driven pixel.
  int         m_h, m_v, m_state, m_good;
  bit         m_phs, m_pvs, m_pend, m_badl;
  logic [10:0] m_mh;
  logic [9:0]  m_mv;

  task automatic model_reset();
    m_h = 0; m_v = 0; m_state = 0; m_good = 0;
    m_phs = 1'b1; m_pvs = 1'b1; m_pend = 1'b0; m_badl = 1'b0;
    m_mh = '0; m_mv = '0;
  endtask

  task automatic model_pixel(input bit hs, input bit vs);
    exp_t e;
    bit   hf, vf, lbad, fgood, tmo;
    e = '{default: 0};
    hf = m_phs && !hs;
    vf = m_pvs && !vs;
    m_phs = hs;
    m_pvs = vs;
    tmo = (m_h == TO - 1);
    lbad = 1'b0;
    fgood = 1'b0;
    if (hf) begin
      m_mh = 11'(m_h + 1);
      e.ls = 1'b1;
      lbad = (m_mh != 11'(HT));
      if (m_pend || vf) begin
        m_mv = 10'(m_v + 1);
        fgood = (m_mv == 10'(VT)) && !m_badl && !lbad;
        e.fs = 1'b1;
        m_v = 0;
        m_pend = 1'b0;
        m_badl = 1'b0;
      end else begin
        if (m_v < 1023) m_v++;
        if (lbad) m_badl = 1'b1;
      end
      m_h = 0;
    end else begin
      if (m_h < 2047) m_h++;
      if (vf) m_pend = 1'b1;
    end
    if (tmo) begin
      e.er = (m_state == 2);
      m_state = 0;
      m_good = 0;
    end else if (m_state == 2) begin
      if (lbad || (e.fs && !fgood)) begin
        e.er = 1'b1;
        m_state = 0;
        m_good = 0;
      end
    end else if (e.fs) begin
      if (fgood) begin
        m_good++;
        m_state = (m_good >= LOCKF) ? 2 : 1;
      end else begin
        m_good = 0;
        m_state = 0;
      end
    end
    e.mh = m_mh;
    e.mv = m_mv;
    e.lk = (m_state == 2);
    e.de = e.lk && m_h >= XL && m_h <= XH && m_v >= YL && m_v <= YH;
    if (e.de) begin
      e.x = 10'(m_h - XL);
      e.y = 9'(m_v - YL);
    end
    sb.push_back(e);
  endtask

  // One pixel: 4 clk, pix_ce on the last one.
  task automatic pixel(input bit hs, input bit vs);
    model_pixel(hs, vs);
    hs_in = hs;
    vs_in = vs;
    repeat (3) @(negedge clk);
    pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0;
  endtask

  task automatic send_line(input int l, input int len);
    for (int p = 0; p < len; p++) pixel(p >= HS_W, l >= VS_W);
  endtask

  task automatic send_frame(input int nlines, input int short_line);
    for (int l = 0; l < nlines; l++) send_line(l, (l == short_line) ? HT - 1 : HT);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_de"}, de, 0);
    check({tag, "_line_start"}, line_start, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_meas_h"}, meas_h, 0);
    check({tag, "_meas_v"}, meas_v, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin : monitor
    bit   ce_s, rs_s;
    exp_t e;
    forever begin
      @(posedge clk);
      ce_s = pix_ce;
      rs_s = rst;
      #1;
      if (!rs_s) begin
        if (ce_s) begin
          check("sb_depth", sb.size(), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("de", de, e.de);
            check("x", x, e.x);
            check("y", y, e.y);
            check("line_start", line_start, e.ls);
            check("frame_start", frame_start, e.fs);
            check("meas_h", meas_h, e.mh);
            check("meas_v", meas_v, e.mv);
            check("locked", locked, e.lk);
            check("err", err, e.er);
          end
        end else begin
          check("pulse_width", {line_start, frame_start, err}, 0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pix_ce = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    repeat (5) pixel(1'b1, 1'b1);
    repeat (3) send_frame(VT, -1);       // lock at the 3rd frame_start
    send_frame(VT, 5);                   // one short line while locked
    repeat (3) send_frame(VT, -1);       // relock
    send_frame(VT - 1, -1);              // short frame
    repeat (3) send_frame(VT, -1);       // relock
    for (int l = 0; l < 3; l++) send_line(l, HT);
    repeat (2100) pixel(1'b1, 1'b1);     // HS stuck high: timeout, saturation
    send_frame(VT, -1);
    send_line(0, HT);
    for (int p = 0; p < 10; p++) pixel(p >= HS_W, 1'b1);

    rst = 1'b1;                          // mid-line reset with pix_ce high
    pix_ce = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    pix_ce = 1'b0;
    model_reset();
    send_line(1, HT);
    send_line(2, HT);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
